seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Parametrised multiplexed 7-segment display driver for the FPGA board top level.
- Takes N packed 4-bit hex nibbles and time-multiplexes them onto one shared segment bus plus N digit anodes.
- Adds features the current 4-digit scanner lacks:
  - built-in hex-to-segment decode;
  - tear-free double-buffered update;
  - leading-zero blanking;
  - per-digit decimal point and blink;
  - 8-level brightness PWM;
  - selectable output polarity.

Parameters:
- DIGITS, 4: number of digits scanned; legal range 1..8.
- SCAN_DIV, 10000: sysclk cycles per digit slot; must be >= 8.
- BLINK_FRAMES, 25: full scan frames per blink half-period.
- SEG_ACTIVE_LOW, 1: 1 means seg/dp drive 0 to light a segment.
- AN_ACTIVE_LOW, 0: 1 means an drives 0 to enable a digit.

Ports:
- sysclk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe; captures digits_in/dp_in/blink_in into the pending buffer.
- digits_in  in  4*DIGITS  packed nibbles; [3:0] is digit 0 (rightmost).
- dp_in  in  DIGITS  decimal point request per digit.
- blink_in  in  DIGITS  blink enable per digit.
- lz_blank  in  1  leading-zero blanking enable; sampled live.
- brightness  in  3  duty level 0..7; sampled at each slot start.
- seg  out  7  segments {g,f,e,d,c,b,a}, registered.
- dp  out  1  decimal point, registered.
- an  out  DIGITS  one-hot digit enable, registered.
- frame_tick  out  1  one-cycle pulse when digit 0 slot begins.

Behaviour:
- Reset (async):
  - slot_cnt = 0, dig_idx = 0, frame_cnt = 0, blink_phase = 0 (visible).
  - Pending and active buffers cleared to 0.
  - seg, dp and an at their inactive level; frame_tick = 0.
- Slot counter:
  - slot_cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - On wrap, dig_idx increments 0..DIGITS-1, then wraps to 0.
  - Scan order is digit 0 first, ascending.
- Frame boundary: cycle where slot_cnt wraps and dig_idx wraps to 0.
  - frame_tick pulses on the following cycle, aligned with the registered outputs.
  - pending is copied to active.
  - frame_cnt increments; at BLINK_FRAMES-1 it clears and blink_phase toggles.
- Load:
  - load=1 writes pending on that edge.
  - If load coincides with a frame boundary, the new inputs go directly to active and pending.
  - Digits mid-frame never change content.
- Brightness:
  - on_cycles = ((brightness_latched+1)*SCAN_DIV)>>3, computed at full width with no overflow; brightness_latched is captured at slot_cnt == 0.
  - Digit is enabled while slot_cnt < on_cycles, otherwise all anodes are inactive.
  - brightness = 7 gives a full slot.
- Leading-zero blanking, when lz_blank=1:
  - Digit k is blank if k != 0 and all active nibbles k..DIGITS-1 are 0.
  - Digit 0 is never blanked.
  - A blanked digit still shows its dp if requested.
- Blink: if active blink bit is set and blink_phase=1, that digit's seg and dp are inactive; the anode still follows the PWM.
- Decode: 0-F standard hex glyphs (b and d lowercase); blank = all segments off.
- Latency: outputs are registered; each reflects the slot_cnt/dig_idx state one cycle earlier.
- Polarity is applied at the output register only; internal logic is active-high.
- DIGITS=1: dig_idx stays 0 and every slot wrap is a frame boundary.
- Reset mid-frame: immediate return to reset values; scan restarts at digit 0.

Decomposition:
- Package seg7_pkg:
  - 16-entry hex-to-segment constant table, active-high;
  - SEG_BLANK constant;
  - helper function for counter width (clog2).
- Sub-module seg7_hex_decode: combinational nibble + blank -> 7-bit segment pattern, instantiated once on the selected digit.

Test Plan:
- Reset then run, DIGITS=4, SCAN_DIV=8, brightness=7, load 16'h12AF -> an steps 0001,0010,0100,1000 every 8 cycles; seg shows F,A,2,1 encodings; frame_tick every 32 cycles.
- Load 16'h0000 then 16'h5678 at slot_cnt=3 of digit 1 -> the current frame keeps showing 0000; the next frame after frame_tick shows 5678. Also assert load exactly on the frame boundary -> 5678 appears in that same frame.
- lz_blank=1, value 16'h0040 -> digits 3 and 2 are blank; digits 1 and 0 show 4 and 0. Value 16'h0000 -> only digit 0 shows "0".
- brightness=0, SCAN_DIV=16 -> an is active for 2 of 16 cycles per slot. brightness=3 -> 8 of 16. Change brightness mid-slot -> takes effect at the next slot.
- BLINK_FRAMES=2, blink_in=4'b0100, dp_in=4'b0100 -> digit 2 seg and dp go off for 2 frames and on for 2; other digits are unaffected; an still pulses.
- Polarity sweep with SEG_ACTIVE_LOW=0 and AN_ACTIVE_LOW=1 -> bitwise inversion of outputs versus defaults. Assert reset mid-slot -> outputs go inactive immediately and the scan restarts at digit 0.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
//------------------------------------------------------------
// Module : seg7_pkg
// Brief  : hex glyph table (active-high) and counter sizing.
// Rev    : 1.0
//------------------------------------------------------------
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Index 0 is the rightmost entry; bit order is {g,f,e,d,c,b,a}.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
//------------------------------------------------------------
// Module : seg7_hex_decode
// Brief  : nibble + blank to active-high segment pattern.
// Rev    : 1.0
//------------------------------------------------------------
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg_hi
);

  always_comb begin
    seg_hi = HEX_SEG[nibble];
    if (blank) seg_hi = SEG_BLANK;
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
//------------------------------------------------------------
// Module : seg7_scan_ctrl
// Brief  : multiplexed N-digit 7-segment scanner with PWM/blink.
// Rev    : 1.0
//------------------------------------------------------------
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 10000,
  parameter int BLINK_FRAMES   = 25,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b0
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_in,
  input  logic                  lz_blank,
  input  logic [2:0]            brightness,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int SW = cnt_width(SCAN_DIV);
  localparam int IW = cnt_width(DIGITS);
  localparam int FW = cnt_width(BLINK_FRAMES);
  localparam int PW = SW + 4;
  localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_ACTIVE_LOW}};

  logic [SW-1:0]       r_slot_cnt;
  logic [IW-1:0]       r_dig_idx;
  logic [FW-1:0]       r_frame_cnt;
  logic                r_blink_phase;
  logic [2:0]          r_bright;
  logic [4*DIGITS-1:0] r_pend_dig, r_act_dig;
  logic [DIGITS-1:0]   r_pend_dp, r_act_dp, r_pend_blk, r_act_blk;

  logic                w_slot_wrap, w_frame_bnd;
  logic [3:0]          w_nib;
  logic                w_sel_dp, w_sel_blk, w_zero_tail, w_lz, w_blink_off, w_on;
  logic [DIGITS-1:0]   w_onehot, w_an_hi;
  logic [2:0]          w_bright_eff;
  logic [PW-1:0]       w_on_cycles;
  logic [6:0]          w_seg_hi;
  logic                w_dp_hi;

  always_comb begin
    w_slot_wrap = (r_slot_cnt == SW'(SCAN_DIV - 1));
    w_frame_bnd = w_slot_wrap && (r_dig_idx == IW'(DIGITS - 1));
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_slot_cnt    <= '0;
      r_dig_idx     <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_bright      <= '0;
    end else begin
      r_slot_cnt <= w_slot_wrap ? '0 : r_slot_cnt + SW'(1);
      if (w_slot_wrap) r_dig_idx <= w_frame_bnd ? '0 : r_dig_idx + IW'(1);
      if (r_slot_cnt == '0) r_bright <= brightness;
      if (w_frame_bnd) begin
        if (r_frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + FW'(1);
        end
      end
    end
  end

  // A load on the boundary edge bypasses pending so it shows in the new frame.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_pend_dig <= '0;
      r_pend_dp  <= '0;
      r_pend_blk <= '0;
      r_act_dig  <= '0;
      r_act_dp   <= '0;
      r_act_blk  <= '0;
    end else begin
      if (load) begin
        r_pend_dig <= digits_in;
        r_pend_dp  <= dp_in;
        r_pend_blk <= blink_in;
      end
      if (w_frame_bnd) begin
        r_act_dig <= load ? digits_in : r_pend_dig;
        r_act_dp  <= load ? dp_in     : r_pend_dp;
        r_act_blk <= load ? blink_in  : r_pend_blk;
      end
    end
  end

  // Walk from the most significant digit down so w_zero_tail covers k..DIGITS-1.
  always_comb begin
    w_nib       = '0;
    w_sel_dp    = 1'b0;
    w_sel_blk   = 1'b0;
    w_zero_tail = 1'b1;
    w_lz        = 1'b0;
    w_onehot    = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_zero_tail = w_zero_tail && (r_act_dig[4*k +: 4] == 4'h0);
      if (r_dig_idx == IW'(k)) begin
        w_nib       = r_act_dig[4*k +: 4];
        w_sel_dp    = r_act_dp[k];
        w_sel_blk   = r_act_blk[k];
        w_lz        = lz_blank && (k != 0) && w_zero_tail;
        w_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    w_bright_eff = (r_slot_cnt == '0) ? brightness : r_bright;
    w_on_cycles  = ((PW'(w_bright_eff) + PW'(1)) * PW'(SCAN_DIV)) >> 3;
    w_on         = PW'(r_slot_cnt) < w_on_cycles;
    w_blink_off  = w_sel_blk && r_blink_phase;
    w_dp_hi      = w_sel_dp && !w_blink_off;
    w_an_hi      = w_on ? w_onehot : '0;
  end

  seg7_hex_decode u_dec (
    .nibble (w_nib),
    .blank  (w_lz || w_blink_off),
    .seg_hi (w_seg_hi)
  );

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      seg        <= SEG_OFF;
      dp         <= SEG_ACTIVE_LOW;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      seg        <= w_seg_hi ^ SEG_OFF;
      dp         <= w_dp_hi ^ SEG_ACTIVE_LOW;
      an         <= w_an_hi ^ AN_OFF;
      frame_tick <= w_frame_bnd;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
//------------------------------------------------------------
// Module : tb_seg7_scan_ctrl
// Brief  : directed bench, default and inverted polarity instances.
// Rev    : 1.0
//------------------------------------------------------------
module tb_seg7_scan_ctrl;

  logic        sysclk = 1'b0;
  logic        reset, load, lz_blank;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, blink_in;
  logic [2:0]  brightness;

  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, ft_a, ft_b;
  logic [3:0]  an_a, an_b;

  int checks = 0;
  int errors = 0;
  int pos    = 0;
  int n      = 0;

  always #5 sysclk = ~sysclk;

  seg7_scan_ctrl #(.DIGITS(4), .SCAN_DIV(16), .BLINK_FRAMES(2),
                   .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b0)) dut_a (
    .sysclk(sysclk), .reset(reset), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .blink_in(blink_in), .lz_blank(lz_blank),
    .brightness(brightness), .seg(seg_a), .dp(dp_a), .an(an_a),
    .frame_tick(ft_a));

  seg7_scan_ctrl #(.DIGITS(4), .SCAN_DIV(16), .BLINK_FRAMES(2),
                   .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)) dut_b (
    .sysclk(sysclk), .reset(reset), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .blink_in(blink_in), .lz_blank(lz_blank),
    .brightness(brightness), .seg(seg_b), .dp(dp_b), .an(an_b),
    .frame_tick(ft_b));

  // Expected values are active-high; dut_a inverts seg/dp, dut_b inverts an.
  task automatic chk(input string tag, input logic [6:0] eseg, input logic edp,
                     input logic [3:0] ean, input logic eft);
    logic [6:0] xseg;
    logic       xdp;
    logic [3:0] xan;
    xseg = ~eseg;
    xdp  = ~edp;
    xan  = ~ean;
    checks++; assert (seg_a === xseg) else begin errors++; $error("FAIL %s seg_a got %h want %h", tag, seg_a, xseg); end
    checks++; assert (dp_a === xdp)   else begin errors++; $error("FAIL %s dp_a got %b want %b", tag, dp_a, xdp); end
    checks++; assert (an_a === ean)   else begin errors++; $error("FAIL %s an_a got %b want %b", tag, an_a, ean); end
    checks++; assert (ft_a === eft)   else begin errors++; $error("FAIL %s ft_a got %b want %b", tag, ft_a, eft); end
    checks++; assert (seg_b === eseg) else begin errors++; $error("FAIL %s seg_b got %h want %h", tag, seg_b, eseg); end
    checks++; assert (dp_b === edp)   else begin errors++; $error("FAIL %s dp_b got %b want %b", tag, dp_b, edp); end
    checks++; assert (an_b === xan)   else begin errors++; $error("FAIL %s an_b got %b want %b", tag, an_b, xan); end
    checks++; assert (ft_b === eft)   else begin errors++; $error("FAIL %s ft_b got %b want %b", tag, ft_b, eft); end
  endtask

  task automatic chk_n(input string tag, input int got, input int want);
    checks++;
    assert (got == want) else begin errors++; $error("FAIL %s got %0d want %0d", tag, got, want); end
  endtask

  // Lands on the negedge where frame_tick is high; that negedge is pos 0.
  task automatic wait_frame(output int steps);
    steps = 0;
    do begin
      @(negedge sysclk);
      steps++;
    end while (!ft_a && steps < 200);
    checks++;
    assert (ft_a === 1'b1) else begin errors++; $error("FAIL frame_wait got %b want 1 after %0d cycles", ft_a, steps); end
    pos = 0;
  endtask

  task automatic at(input int p);
    repeat (p - pos) @(negedge sysclk);
    pos = p;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load = 1'b0; lz_blank = 1'b0; brightness = 3'd7;
    digits_in = 16'h0; dp_in = 4'h0; blink_in = 4'h0;
    repeat (3) @(negedge sysclk);
    chk("reset", 7'h00, 1'b0, 4'b0000, 1'b0);

    reset = 1'b0;
    @(negedge sysclk);
    chk("run_d0", 7'h3F, 1'b0, 4'b0001, 1'b0);
    digits_in = 16'h12AF; load = 1'b1;
    @(negedge sysclk);
    load = 1'b0;
    wait_frame(n);
    chk_n("first_frame_len", n, 62);

    // Frame A: 12AF; a mid-frame load of 5678 must not disturb it
    chk("a_tick", 7'h3F, 1'b0, 4'b1000, 1'b1);
    at(1);  chk("a_d0", 7'h71, 1'b0, 4'b0001, 1'b0);
    at(16); chk("a_d0_end", 7'h71, 1'b0, 4'b0001, 1'b0);
    at(17); chk("a_d1", 7'h77, 1'b0, 4'b0010, 1'b0);
    at(19); digits_in = 16'h5678; load = 1'b1;
    at(20); load = 1'b0;
    at(33); chk("a_d2", 7'h5B, 1'b0, 4'b0100, 1'b0);
    at(49); chk("a_d3", 7'h06, 1'b0, 4'b1000, 1'b0);
    at(63); chk("a_pre_tick", 7'h06, 1'b0, 4'b1000, 1'b0);
    wait_frame(n);
    chk_n("frame_len", n, 1);

    // Frame B: 5678; load on the boundary edge
    at(1);  chk("b_d0", 7'h7F, 1'b0, 4'b0001, 1'b0);
    at(17); chk("b_d1", 7'h07, 1'b0, 4'b0010, 1'b0);
    at(33); chk("b_d2", 7'h7D, 1'b0, 4'b0100, 1'b0);
    at(49); chk("b_d3", 7'h6D, 1'b0, 4'b1000, 1'b0);
    at(63); digits_in = 16'h3E4B; load = 1'b1;
    wait_frame(n);
    load = 1'b0;

    // Frame C: boundary load shows immediately
    chk("c_tick", 7'h6D, 1'b0, 4'b1000, 1'b1);
    at(1);  chk("c_d0", 7'h7C, 1'b0, 4'b0001, 1'b0);
    at(17); chk("c_d1", 7'h66, 1'b0, 4'b0010, 1'b0);
    at(33); chk("c_d2", 7'h79, 1'b0, 4'b0100, 1'b0);
    at(40); lz_blank = 1'b1; digits_in = 16'h0040; dp_in = 4'b1000; load = 1'b1;
    at(41); load = 1'b0;
    at(49); chk("c_d3", 7'h4F, 1'b0, 4'b1000, 1'b0);
    wait_frame(n);

    // Frame D: 0040 with blanking, dp on blanked digit 3
    at(1);  chk("d_d0", 7'h3F, 1'b0, 4'b0001, 1'b0);
    at(17); chk("d_d1", 7'h66, 1'b0, 4'b0010, 1'b0);
    at(33); chk("d_d2_blank", 7'h00, 1'b0, 4'b0100, 1'b0);
    at(49); chk("d_d3_blank_dp", 7'h00, 1'b1, 4'b1000, 1'b0);
    at(50); digits_in = 16'h0000; dp_in = 4'b0000; load = 1'b1;
    at(51); load = 1'b0;
    wait_frame(n);

    // Frame E: 0000 blanked, brightness changes
    at(1);  chk("e_d0", 7'h3F, 1'b0, 4'b0001, 1'b0);
    at(17); chk("e_d1_blank", 7'h00, 1'b0, 4'b0010, 1'b0);
    at(20); brightness = 3'd0;
    at(21); chk("e_mid_slot_bright", 7'h00, 1'b0, 4'b0010, 1'b0);
    at(33); chk("e_b0_s0", 7'h00, 1'b0, 4'b0100, 1'b0);
    at(34); chk("e_b0_s1", 7'h00, 1'b0, 4'b0100, 1'b0);
    at(35); chk("e_b0_s2", 7'h00, 1'b0, 4'b0000, 1'b0);
    at(40); brightness = 3'd3;
    at(41); chk("e_b0_s8", 7'h00, 1'b0, 4'b0000, 1'b0);
    at(56); chk("e_b3_s7", 7'h00, 1'b0, 4'b1000, 1'b0);
    at(57); chk("e_b3_s8", 7'h00, 1'b0, 4'b0000, 1'b0);
    at(58); brightness = 3'd7;

    // Asynchronous reset mid-slot, then restart and blink
    at(60); reset = 1'b1;
    #1;
    chk("reset_async", 7'h00, 1'b0, 4'b0000, 1'b0);
    @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);
    chk("restart_d0", 7'h3F, 1'b0, 4'b0001, 1'b0);
    lz_blank = 1'b0; digits_in = 16'h1234; dp_in = 4'b0100; blink_in = 4'b0100;
    load = 1'b1;
    @(negedge sysclk);
    load = 1'b0;
    wait_frame(n);
    chk_n("restart_frame_len", n, 62);

    at(1);  chk("f1_d0", 7'h66, 1'b0, 4'b0001, 1'b0);
    at(33); chk("f1_d2_on", 7'h5B, 1'b1, 4'b0100, 1'b0);
    wait_frame(n);
    at(17); chk("f2_d1", 7'h4F, 1'b0, 4'b0010, 1'b0);
    at(33); chk("f2_d2_off", 7'h00, 1'b0, 4'b0100, 1'b0);
    wait_frame(n);
    at(33); chk("f3_d2_off", 7'h00, 1'b0, 4'b0100, 1'b0);
    wait_frame(n);
    at(33); chk("f4_d2_on", 7'h5B, 1'b1, 4'b0100, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
